// File: rtl/ldpc_pkg.sv
// ldpc_pkg: LLR word type, saturation constants and clamp helpers
package ldpc_pkg;
  localparam int W = 32;
  localparam int WIDE = W + 3;
  typedef logic signed [W-1:0] llr_t;
  typedef logic signed [WIDE-1:0] wide_t;
  localparam llr_t LMAX = {1'b0, {(W-1){1'b1}}};
  function automatic llr_t sat_llr(input wide_t x);
    if (x > wide_t'(LMAX)) return LMAX;
    else if (x < -wide_t'(LMAX)) return -LMAX;
    else return llr_t'(x);
  endfunction
  function automatic llr_t abs_sat(input llr_t v);
    if (v == {1'b1, {(W-1){1'b0}}}) return LMAX;
    else if (v < 0) return -v;
    else return v;
  endfunction
endpackage

// File: rtl/ldpc_check_node_minsum.sv
// ldpc_check_node_minsum: combinational min-sum reduction over DEG var-to-check messages
module ldpc_check_node_minsum
  import ldpc_pkg::*;
#(
  parameter int DEG = 4
) (
  input  logic [DEG*W-1:0] vars_i,
  output llr_t             msg_o
);
  llr_t mag;
  logic sgn;
  logic any_zero;
  always_comb begin
    mag = LMAX;
    sgn = 1'b0;
    any_zero = 1'b0;
    for (int k = 0; k < DEG; k++) begin
      if (abs_sat(llr_t'(vars_i[k*W +: W])) < mag) mag = abs_sat(llr_t'(vars_i[k*W +: W]));
      sgn = sgn ^ vars_i[k*W + W - 1];
      any_zero = any_zero | (vars_i[k*W +: W] == '0);
    end
  end
  assign msg_o = any_zero ? '0 : sgn ? -mag : mag;
endmodule

// File: rtl/ldpc_node_kernel.sv
// ldpc_node_kernel: registered channel evidence, min-sum check message and variable belief
module ldpc_node_kernel
  import ldpc_pkg::*;
#(
  parameter int N_BITS = 10,
  parameter int DEG = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [N_BITS-1:0]   received_packet,
  input  logic [W-1:0]        bit_error_log_prob,
  input  logic [DEG*W-1:0]    neighbour_vars,
  input  logic [DEG*W-1:0]    neighbour_checks,
  output logic                out_valid,
  output logic [N_BITS*W-1:0] channel_evidence,
  output llr_t                check_to_var_message,
  output llr_t                belief,
  output logic                corrected_bit
);
  logic [W-1:0] lc;
  logic [N_BITS*W-1:0] evidence_d, evidence_q;
  llr_t c2v_d, c2v_q, belief_d, belief_q;
  wide_t acc;
  logic valid_q, bit_q;
  assign lc = bit_error_log_prob > LMAX ? LMAX : bit_error_log_prob;
  always_comb begin
    for (int i = 0; i < N_BITS; i++)
      evidence_d[i*W +: W] = received_packet[i] ? -llr_t'(lc) : llr_t'(lc);
  end
  always_comb begin
    acc = '0;
    for (int k = 0; k < DEG; k++) acc = acc + wide_t'(llr_t'(neighbour_checks[k*W +: W]));
    belief_d = sat_llr(acc);
  end
  ldpc_check_node_minsum #(.DEG(DEG)) u_minsum (
    .vars_i (neighbour_vars),
    .msg_o  (c2v_d)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      evidence_q <= '0;
      c2v_q <= '0;
      belief_q <= '0;
      bit_q <= 1'b0;
    end else begin
      valid_q <= in_valid;
      if (in_valid) begin
        evidence_q <= evidence_d;
        c2v_q <= c2v_d;
        belief_q <= belief_d;
        bit_q <= belief_d[W-1];
      end
    end
  end
  assign out_valid = valid_q;
  assign channel_evidence = evidence_q;
  assign check_to_var_message = c2v_q;
  assign belief = belief_q;
  assign corrected_bit = bit_q;
endmodule

// File: tb/tb_ldpc_node_kernel.sv
// tb_ldpc_node_kernel: directed-vector checks of the LDPC node kernel
module tb_ldpc_node_kernel;
  localparam int NB = 10;
  localparam int D = 4;
  localparam int WW = 32;
  localparam logic [31:0] MAXP = 32'h7FFF_FFFF;
  localparam logic [31:0] MAXN = 32'h8000_0001;
  localparam logic [31:0] MINV = 32'h8000_0000;
  logic clk = 0;
  logic rst = 0;
  logic in_valid = 0;
  logic [NB-1:0] received_packet = '0;
  logic [WW-1:0] bit_error_log_prob = '0;
  logic [D*WW-1:0] neighbour_vars = '0;
  logic [D*WW-1:0] neighbour_checks = '0;
  logic out_valid;
  logic [NB*WW-1:0] channel_evidence;
  logic [WW-1:0] check_to_var_message;
  logic [WW-1:0] belief;
  logic corrected_bit;
  int passed = 0;
  int total = 0;

  ldpc_node_kernel #(.N_BITS(NB), .DEG(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .received_packet(received_packet), .bit_error_log_prob(bit_error_log_prob),
    .neighbour_vars(neighbour_vars), .neighbour_checks(neighbour_checks),
    .out_valid(out_valid), .channel_evidence(channel_evidence),
    .check_to_var_message(check_to_var_message), .belief(belief),
    .corrected_bit(corrected_bit)
  );

  always #5 clk = ~clk;

  function automatic logic [D*WW-1:0] p4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [NB-1:0] pkt, input logic [31:0] l,
                      input logic [D*WW-1:0] v, input logic [D*WW-1:0] c);
    received_packet = pkt;
    bit_error_log_prob = l;
    neighbour_vars = v;
    neighbour_checks = c;
    in_valid = 1;
    tick();
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    beat(10'h3A5, 32'd77, p4(-32'sd3, 32'd4, 32'd5, 32'd6), p4(32'd1, 32'd2, 32'd3, 32'd4));
    total++; if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid); else passed++;
    total++; if (channel_evidence !== '0) $display("FAIL reset_evidence got %h want 0", channel_evidence); else passed++;
    total++; if (check_to_var_message !== 32'd0) $display("FAIL reset_c2v got %h want 0", check_to_var_message); else passed++;
    total++; if (belief !== 32'd0 || corrected_bit !== 1'b0) $display("FAIL reset_belief got %h/%b want 0/0", belief, corrected_bit); else passed++;
    rst = 0;
  endtask

  task automatic test_evidence();
    logic [NB*WW-1:0] exp13, expmax;
    logic [31:0] l13 [NB] = '{-32'sd13, -32'sd13, 32'd13, 32'd13, -32'sd13, 32'd13, 32'd13, -32'sd13, 32'd13, -32'sd13};
    for (int i = 0; i < NB; i++) begin
      exp13[i*WW +: WW] = l13[i];
      expmax[i*WW +: WW] = l13[i][31] ? MAXN : MAXP;
    end
    beat(10'b10_1001_0011, 32'd13, p4(32'd1, 32'd1, 32'd1, 32'd1), '0);
    total++; if (out_valid !== 1'b1) $display("FAIL ev_valid got %b want 1", out_valid); else passed++;
    total++; if (channel_evidence !== exp13) $display("FAIL ev_l13 got %h want %h", channel_evidence, exp13); else passed++;
    beat(10'b10_1001_0011, 32'hFFFF_FFFF, p4(32'd1, 32'd1, 32'd1, 32'd1), '0);
    total++; if (channel_evidence !== expmax) $display("FAIL ev_sat got %h want %h", channel_evidence, expmax); else passed++;
  endtask

  task automatic test_check_to_var();
    logic [D*WW-1:0] vin [4] = '{p4(-32'sd3, 32'd100, 32'd55, 32'd100), p4(32'd5, -32'sd7, -32'sd2, 32'd9),
                                 p4(32'd0, -32'sd4, 32'd6, 32'd8), p4(MINV, MINV, 32'd7, 32'd9)};
    logic [31:0] exp [4] = '{-32'sd3, 32'd2, 32'd0, 32'd7};
    for (int t = 0; t < 4; t++) begin
      beat('0, 32'd1, vin[t], '0);
      total++; if (check_to_var_message !== exp[t]) $display("FAIL c2v_%0d got %0d want %0d", t, $signed(check_to_var_message), $signed(exp[t])); else passed++;
    end
  endtask

  task automatic test_belief();
    logic [D*WW-1:0] cin [5] = '{p4(32'd2, 32'd3, 32'd3, 32'd2), p4(-32'sd5, 32'd1, 32'd1, 32'd1),
                                 p4(32'd1, -32'sd1, 32'd2, -32'sd2), p4(MAXP, MAXP, MAXP, MAXP), p4(MINV, MINV, MINV, MINV)};
    logic [31:0] eb [5] = '{32'd10, -32'sd2, 32'd0, MAXP, MAXN};
    logic ebit [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int t = 0; t < 5; t++) begin
      beat('0, 32'd1, p4(32'd1, 32'd1, 32'd1, 32'd1), cin[t]);
      total++; if (belief !== eb[t] || corrected_bit !== ebit[t])
        $display("FAIL belief_%0d got %0d/%b want %0d/%b", t, $signed(belief), corrected_bit, $signed(eb[t]), ebit[t]); else passed++;
    end
  endtask

  task automatic test_hold();
    beat(10'h001, 32'd9, p4(32'd4, 32'd6, 32'd8, 32'd10), p4(-32'sd5, 32'd1, 32'd1, 32'd1));
    received_packet = 10'h3FF;
    bit_error_log_prob = 32'd500;
    neighbour_vars = p4(-32'sd1, 32'd2, 32'd3, 32'd4);
    neighbour_checks = p4(32'd50, 32'd50, 32'd50, 32'd50);
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL hold_valid got %b want 0", out_valid); else passed++;
    total++; if (channel_evidence[WW-1:0] !== -32'sd9 || channel_evidence[2*WW-1:WW] !== 32'd9)
      $display("FAIL hold_evidence got %h want lane0=-9 lane1=9", channel_evidence[2*WW-1:0]); else passed++;
    total++; if (check_to_var_message !== 32'd4) $display("FAIL hold_c2v got %0d want 4", $signed(check_to_var_message)); else passed++;
    total++; if (belief !== -32'sd2 || corrected_bit !== 1'b1) $display("FAIL hold_belief got %0d/%b want -2/1", $signed(belief), corrected_bit); else passed++;
  endtask

  task automatic test_back_to_back();
    received_packet = 10'h000; bit_error_log_prob = 32'd3;
    neighbour_vars = p4(32'd20, 32'd30, 32'd40, 32'd50); neighbour_checks = p4(32'd1, 32'd1, 32'd1, 32'd1);
    in_valid = 1;
    tick();
    total++; if (out_valid !== 1'b1 || check_to_var_message !== 32'd20 || belief !== 32'd4 || channel_evidence[WW-1:0] !== 32'd3)
      $display("FAIL b2b_first got v=%b c2v=%0d b=%0d e0=%0d want 1/20/4/3", out_valid, $signed(check_to_var_message), $signed(belief), $signed(channel_evidence[WW-1:0])); else passed++;
    received_packet = 10'h3FF; bit_error_log_prob = 32'd8;
    neighbour_vars = p4(-32'sd11, 32'd30, 32'd40, 32'd50); neighbour_checks = p4(-32'sd9, 32'd1, 32'd1, 32'd1);
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || check_to_var_message !== -32'sd11 || belief !== -32'sd6 || channel_evidence[WW-1:0] !== -32'sd8)
      $display("FAIL b2b_second got v=%b c2v=%0d b=%0d e0=%0d want 1/-11/-6/-8", out_valid, $signed(check_to_var_message), $signed(belief), $signed(channel_evidence[WW-1:0])); else passed++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL b2b_idle got %b want 0", out_valid); else passed++;
  endtask

  task automatic test_reset_mid();
    beat(10'h0FF, 32'd21, p4(32'd3, 32'd4, 32'd5, 32'd6), p4(32'd7, 32'd7, 32'd7, 32'd7));
    total++; if (out_valid !== 1'b1 || belief !== 32'd28) $display("FAIL mid_pre got %b/%0d want 1/28", out_valid, $signed(belief)); else passed++;
    rst = 1;
    beat(10'h0FF, 32'd21, p4(32'd3, 32'd4, 32'd5, 32'd6), p4(-32'sd7, 32'd7, -32'sd7, -32'sd7));
    total++; if (out_valid !== 1'b0 || channel_evidence !== '0 || check_to_var_message !== 32'd0 || belief !== 32'd0 || corrected_bit !== 1'b0)
      $display("FAIL mid_reset got v=%b c2v=%0d b=%0d bit=%b want all 0", out_valid, $signed(check_to_var_message), $signed(belief), corrected_bit); else passed++;
    rst = 0;
  endtask

  initial begin
    tick();
    test_reset();
    test_evidence();
    test_check_to_var();
    test_belief();
    test_hold();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ldpc_node_kernel.md
Name: ldpc_node_kernel

Overview:
- Registered arithmetic kernel for a min-sum LDPC belief-propagation decoder.
- Computes three results each cycle from one shared input beat:
  - channel-evidence LLRs for a received packet;
  - a check-to-variable message, using min-sum;
  - a variable-node belief with its hard decision.
- Sits between packet capture and the iterative decoder controller, which schedules messages through it.

Parameters:
- N_BITS, 10, packet length (number of channel-evidence lanes).
- DEG, 4, node degree (number of neighbour messages per check/belief computation).
- W, 32, LLR word width (two's complement, signed).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input beat qualifier.
- received_packet  in  N_BITS  hard channel bits; bit i is packet bit i.
- bit_error_log_prob  in  W  unsigned LLR magnitude L = log((1-p)/p).
- neighbour_vars  in  DEG*W  signed var-to-check messages; entry k is bits [k*W +: W].
- neighbour_checks  in  DEG*W  signed check-to-var messages; same packing.
- out_valid  out  1  output qualifier.
- channel_evidence  out  N_BITS*W  signed; entry i is bits [i*W +: W].
- check_to_var_message  out  W  signed.
- belief  out  W  signed.
- corrected_bit  out  1  hard decision.

Behaviour:
- Clocking and reset:
  - All outputs are registered; latency is exactly 1 cycle.
  - out_valid is in_valid delayed by one cycle.
  - Data registers load only when in_valid=1; otherwise they hold their value.
  - On rst=1 at a clock edge, all outputs go to 0 (out_valid=0, corrected_bit=0). Reset has priority over in_valid.
- Saturation rules:
  - LMAX = 2^(W-1)-1.
  - Magnitude Lc = min(bit_error_log_prob, LMAX).
  - All signed results saturate to [-LMAX, +LMAX]; -2^(W-1) is never produced.
- Channel evidence, per lane i:
  - received_packet[i]=0 gives +Lc; received_packet[i]=1 gives -Lc.
  - All lanes are computed in parallel.
- Check-to-var, min-sum over all DEG entries (the caller supplies only the extrinsic neighbours):
  - magnitude = min over k of |v_k|, where |−2^(W-1)| is treated as LMAX.
  - sign = XOR of the sign bits of all v_k; a zero entry counts as positive.
  - result = sign ? -magnitude : +magnitude. If any v_k = 0, the result is 0.
- Belief:
  - belief = sum of the DEG neighbour_checks, accumulated at W+3 bits, then saturated to W bits.
  - corrected_bit = 1 iff belief < 0 (strictly); belief = 0 gives corrected_bit = 0.
  - corrected_bit is derived from the saturated belief value.
- Simultaneous events: the three computations are independent and all update on the same in_valid beat.

Decomposition:
- Package ldpc_pkg holds:
  - the W/LMAX constants;
  - typedef llr_t (signed [W-1:0]);
  - function sat_llr (wide signed → llr_t clamp);
  - function abs_sat (llr_t → magnitude clamped to LMAX).
- One sub-module is natural: ldpc_check_node_minsum, a combinational min-sum reduction over DEG inputs instantiated inside the kernel.
- Channel evidence and belief stay inline.

Test Plan:
- Reset: hold rst=1 with in_valid=1 and arbitrary inputs → next edge all outputs 0 and out_valid=0. Assert rst mid-stream → outputs cleared on that edge.
- Channel evidence: L=13, packet bits[0..9]=1,1,0,0,1,0,0,1,0,1, in_valid=1 → one cycle later evidence = -13,-13,+13,+13,-13,+13,+13,-13,+13,-13, out_valid=1. L=0xFFFFFFFF → all lanes ±(2^31-1).
- Check-to-var, sign and magnitude cases:
  - vars {-3,100,55,100} → -3;
  - {5,-7,-2,9} → +2;
  - {0,-4,6,8} → 0;
  - {-2^31,-2^31,7,9} → +7.
- Belief, sign cases:
  - checks {2,3,3,2} → belief 10, corrected_bit 0;
  - {-5,1,1,1} → -2, bit 1;
  - {1,-1,2,-2} → 0, bit 0.
- Belief saturation: checks all 2^31-1 → belief 2^31-1, bit 0; all -2^31 → belief -(2^31-1), bit 1.
- Hold and back-to-back:
  - in_valid=0 with changed inputs → outputs unchanged, out_valid=0;
  - two consecutive in_valid beats → two consecutive out_valid cycles with matching results.
